divider_ctrl: RTL and testbench

DIVIDER_CTRL -- requirements
Module: divider_ctrl

---
 rtl/divider_ctrl_pkg.sv | 14 +
 rtl/tick_channel.sv | 60 ++++++
 rtl/divider_ctrl.sv | 102 ++++++++++
 tb/tb_divider_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_ctrl_pkg.sv
// Shared definitions for the divider controller.
//   state_e : FSM encoding (IDLE=0, RUN=1, PAUSE=2; 3 unused)
//   NumChan : number of rate-enable channels
package divider_ctrl_pkg;

    localparam int unsigned NumChan = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } state_e;

endpackage

// File: rtl/tick_channel.sv
// One programmable rate-enable channel: divisor register, counter and compare.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (divisor <= DEF_DIV, counter/tick <= 0)
//   run    : count this cycle
//   clr    : force counter and tick to 0
//   load   : load div_in into the divisor and clear the counter
//   div_in : new divisor value
//   tick   : registered one-cycle pulse every 'divisor' run cycles; divisor 0 disables
module tick_channel #(
    parameter int unsigned CNT_W   = 26,
    parameter int unsigned DEF_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    output logic             tick
);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr || load || (div_q == '0)) begin
            cnt_d = '0;
        end else if (run) begin
            // cnt_q never exceeds div_q-1, so the increment cannot wrap.
            if (cnt_q == div_q - CNT_W'(1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= CNT_W'(DEF_DIV);
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            if (load) begin
                div_q <= div_in;
            end
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/divider_ctrl.sv
// Four-channel clock-rate enable generator with IDLE/RUN/PAUSE control.
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   start/pause/stop : single-cycle control pulses (priority stop > pause > start)
//   cfg_valid/ready  : divisor write handshake; accepted only in IDLE or PAUSE
//   cfg_sel, cfg_div : target channel and new divisor (0 disables the channel)
//   tick[3:0]        : per-channel one-cycle rate enables
//   LED              : toggles on every channel-0 tick, cleared in IDLE
//   state            : IDLE=0, RUN=1, PAUSE=2
module divider_ctrl
    import divider_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 26,
    parameter int unsigned DEF_DIV = 50_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
    input  logic               stop,
    input  logic               cfg_valid,
    input  logic [1:0]         cfg_sel,
    input  logic [CNT_W-1:0]   cfg_div,
    output logic               cfg_ready,
    output logic [NumChan-1:0] tick,
    output logic               LED,
    output logic [1:0]         state
);

    state_e             state_q;
    state_e             state_d;
    logic               accept;
    logic               run;
    logic               clr;
    logic [NumChan-1:0] load;
    logic               led_q;

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_d = StRun;
                StRun:   if (pause) state_d = StPause;
                StPause: if (pause) state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign cfg_ready = (state_q == StIdle) || (state_q == StPause);
    assign accept    = cfg_valid && cfg_ready;
    assign run       = (state_q == StRun);
    // Clearing on state_d covers both holding IDLE and the edge that enters it.
    assign clr       = (state_d == StIdle);

    always_comb begin
        load = '0;
        for (int i = 0; i < NumChan; i++) begin
            load[i] = accept && (cfg_sel == 2'(i));
        end
    end

    for (genvar i = 0; i < NumChan; i++) begin : g_chan
        tick_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .run    (run),
            .clr    (clr),
            .load   (load[i]),
            .div_in (cfg_div),
            .tick   (tick[i])
        );
    end

    // led_q holds the parity of channel-0 ticks already retired; XOR with the
    // registered tick[0] makes LED change on the same edge that raises tick[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= 1'b0;
        end else if (clr) begin
            led_q <= 1'b0;
        end else if (tick[0]) begin
            led_q <= ~led_q;
        end
    end

    assign LED   = led_q ^ tick[0];
    assign state = state_q;

endmodule

// File: tb/tb_divider_ctrl.sv
// Self-checking bench for divider_ctrl (CNT_W=8, DEF_DIV=5).
module tb_divider_ctrl;

    localparam int CW = 8;
    localparam int DD = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          stop = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [1:0]    cfg_sel = 2'd0;
    logic [CW-1:0] cfg_div = '0;
    logic          cfg_ready;
    logic [3:0]    tick;
    logic          LED;
    logic [1:0]    state;

    int vectors = 0;
    int errors  = 0;

    // Reference model: per-channel count of RUN edges since last clear.
    int         m_state;
    int         m_div [4];
    int         m_runs[4];
    logic [3:0] m_tick;
    logic       m_led;

    divider_ctrl #(
        .CNT_W   (CW),
        .DEF_DIV (DD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_sel   (cfg_sel),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .tick      (tick),
        .LED       (LED),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0;
        m_tick  = 4'h0;
        m_led   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_div[i]  = DD;
            m_runs[i] = 0;
        end
    endtask

    task automatic model_edge();
        int   nxt;
        logic acc;
        acc = cfg_valid && (m_state != 1);
        nxt = m_state;
        if (stop) nxt = 0;
        else if (pause && m_state == 1) nxt = 2;
        else if (pause && m_state == 2) nxt = 1;
        else if (start && m_state == 0) nxt = 1;
        for (int i = 0; i < 4; i++) begin
            if (nxt == 0 || (acc && int'(cfg_sel) == i) || m_div[i] == 0) begin
                m_runs[i] = 0;
                m_tick[i] = 1'b0;
            end else if (m_state == 1) begin
                m_runs[i]++;
                m_tick[i] = (m_runs[i] % m_div[i] == 0);
            end else begin
                m_tick[i] = 1'b0;
            end
        end
        if (acc) m_div[int'(cfg_sel)] = int'(cfg_div);
        if (nxt == 0) m_led = 1'b0;
        else if (m_tick[0]) m_led = ~m_led;
        m_state = nxt;
    endtask

    function automatic logic [7:0] exp_vec();
        return {2'(m_state), (m_state != 1), m_led, m_tick};
    endfunction

    // Advance one clock: model follows the edge, outputs settle 1ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        start     = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start     = 1'($urandom);
            cfg_valid = 1'($urandom);
            cfg_sel   = 2'($urandom);
            cfg_div   = 8'($urandom);
            @(posedge clk);
            #1;
            vectors++;
            if ({state, cfg_ready, LED, tick} !== 8'b00_1_0_0000) begin
                errors++;
                $display("FAIL reset_hold: got %b want %b", {state, cfg_ready, LED, tick},
                         8'b00_1_0_0000);
            end
        end
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_sel   = 2'd0;
        cfg_div   = '0;
        #2 rst_n = 1'b1;
        model_reset();
        step();
        vectors++;
        if ({state, cfg_ready, LED, tick} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", {state, cfg_ready, LED, tick}, exp_vec());
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        start = 1'b1;
        step();
        for (int c = 1; c <= 15; c++) begin
            step();
            exp = {2'd1, 1'b0, 1'((c / 5) % 2), (c % 5 == 0) ? 4'hF : 4'h0};
            vectors++;
            if ({state, cfg_ready, LED, tick} !== exp) begin
                errors++;
                $display("FAIL basic_period c=%0d: got %b want %b", c,
                         {state, cfg_ready, LED, tick}, exp);
            end
            vectors++;
            if ({state, cfg_ready, LED, tick} !== exp_vec()) begin
                errors++;
                $display("FAIL basic_model c=%0d: got %b want %b", c,
                         {state, cfg_ready, LED, tick}, exp_vec());
            end
        end
        stop = 1'b1;
        step();
        vectors++;
        if ({state, cfg_ready, LED, tick} !== 8'b00_1_0_0000) begin
            errors++;
            $display("FAIL basic_stop: got %b want %b", {state, cfg_ready, LED, tick}, 8'b00_1_0_0000);
        end
    endtask

    task automatic test_cfg_idle();
        logic [7:0] exp;
        logic       t5;
        cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_div = 8'd1;
        step();
        cfg_valid = 1'b1; cfg_sel = 2'd1; cfg_div = 8'd0;
        step();
        start = 1'b1;
        step();
        for (int c = 1; c <= 12; c++) begin
            step();
            t5  = (c % 5 == 0);
            exp = {2'd1, 1'b0, 1'((c / 5) % 2), t5, 1'b1, 1'b0, t5};
            vectors++;
            if ({state, cfg_ready, LED, tick} !== exp) begin
                errors++;
                $display("FAIL cfg_idle_ticks c=%0d: got %b want %b", c,
                         {state, cfg_ready, LED, tick}, exp);
            end
        end
        stop = 1'b1;
        step();
        cfg_valid = 1'b1; cfg_sel = 2'd1; cfg_div = 8'd5;
        step();
        cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_div = 8'd5;
        step();
        vectors++;
        if ({state, cfg_ready, LED, tick} !== exp_vec()) begin
            errors++;
            $display("FAIL cfg_idle_restore: got %b want %b", {state, cfg_ready, LED, tick}, exp_vec());
        end
    endtask

    task automatic test_pause();
        logic [7:0] exp;
        start = 1'b1;
        step();
        step();
        step();
        pause = 1'b1;
        step();
        for (int c = 1; c <= 10; c++) begin
            step();
            vectors++;
            if ({state, cfg_ready, LED, tick} !== 8'b10_1_0_0000) begin
                errors++;
                $display("FAIL pause_hold c=%0d: got %b want %b", c,
                         {state, cfg_ready, LED, tick}, 8'b10_1_0_0000);
            end
        end
        pause = 1'b1;
        step();
        for (int c = 1; c <= 2; c++) begin
            step();
            exp = (c == 2) ? 8'b01_0_1_1111 : 8'b01_0_0_0000;
            vectors++;
            if ({state, cfg_ready, LED, tick} !== exp) begin
                errors++;
                $display("FAIL pause_resume c=%0d: got %b want %b", c,
                         {state, cfg_ready, LED, tick}, exp);
            end
        end
    endtask

    task automatic test_cfg_run_pause();
        // In RUN: write must be refused.
        cfg_valid = 1'b1; cfg_sel = 2'd3; cfg_div = 8'd7;
        #0;
        vectors++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL cfg_ready_run: got %b want 0", cfg_ready);
        end
        step();
        for (int c = 1; c <= 10; c++) begin
            step();
            vectors++;
            if ({state, cfg_ready, LED, tick} !== exp_vec()) begin
                errors++;
                $display("FAIL cfg_run_unchanged c=%0d: got %b want %b", c,
                         {state, cfg_ready, LED, tick}, exp_vec());
            end
        end
        pause = 1'b1;
        step();
        cfg_valid = 1'b1; cfg_sel = 2'd3; cfg_div = 8'd7;
        #0;
        vectors++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ready_pause: got %b want 1", cfg_ready);
        end
        step();
        pause = 1'b1;
        step();
        for (int c = 1; c <= 14; c++) begin
            step();
            vectors++;
            if (tick[3] !== (c % 7 == 0)) begin
                errors++;
                $display("FAIL cfg_pause_load c=%0d: got tick3=%b want %b", c, tick[3], (c % 7 == 0));
            end
            vectors++;
            if ({state, cfg_ready, LED, tick} !== exp_vec()) begin
                errors++;
                $display("FAIL cfg_pause_model c=%0d: got %b want %b", c,
                         {state, cfg_ready, LED, tick}, exp_vec());
            end
        end
    endtask

    task automatic test_stop_reset();
        stop = 1'b1; pause = 1'b1;
        step();
        vectors++;
        if ({state, cfg_ready, LED, tick} !== 8'b00_1_0_0000) begin
            errors++;
            $display("FAIL stop_pause: got %b want %b", {state, cfg_ready, LED, tick}, 8'b00_1_0_0000);
        end
        start = 1'b1;
        step();
        for (int c = 1; c <= 7; c++) step();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({state, cfg_ready, LED, tick} !== 8'b00_1_0_0000) begin
            errors++;
            $display("FAIL async_reset: got %b want %b", {state, cfg_ready, LED, tick}, 8'b00_1_0_0000);
        end
        model_reset();
        #3 rst_n = 1'b1;
        start = 1'b1;
        step();
        for (int c = 1; c <= 10; c++) begin
            step();
            vectors++;
            if (tick !== ((c % 5 == 0) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL reset_div_default c=%0d: got %b want %b", c, tick,
                         (c % 5 == 0) ? 4'hF : 4'h0);
            end
        end
        stop = 1'b1;
        step();
    endtask

    task automatic test_wide();
        cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = 8'd255;
        step();
        start = 1'b1;
        step();
        for (int c = 1; c <= 260; c++) begin
            step();
            vectors++;
            if (tick[0] !== (c == 255)) begin
                errors++;
                $display("FAIL wide_div c=%0d: got %b want %b", c, tick[0], (c == 255));
            end
            vectors++;
            if ({state, cfg_ready, LED, tick} !== exp_vec()) begin
                errors++;
                $display("FAIL wide_model c=%0d: got %b want %b", c,
                         {state, cfg_ready, LED, tick}, exp_vec());
            end
        end
        stop = 1'b1;
        step();
        cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = 8'd5;
        step();
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 500; n++) begin
            r         = int'($urandom_range(0, 19));
            start     = (r <= 2);
            pause     = (r == 3) || (r == 4);
            stop      = (r == 5) || ($urandom_range(0, 40) == 0);
            cfg_valid = ($urandom_range(0, 4) == 0);
            cfg_sel   = 2'($urandom);
            cfg_div   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            step();
            vectors++;
            if ({state, cfg_ready, LED, tick} !== exp_vec()) begin
                errors++;
                $display("FAIL random n=%0d: got %b want %b", n,
                         {state, cfg_ready, LED, tick}, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_cfg_idle();
        test_pause();
        test_cfg_run_pause();
        test_stop_reset();
        test_wide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
